traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter T_BASE, default 6, base main-green duration in ticks (legal 1..15).
REQ-002 Parameter T_EXT, default 3, extension, walk and side-green duration in ticks (legal 1..15).
REQ-003 Parameter T_YEL, default 2, yellow duration in ticks (legal 1..15).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Reset_sincronico  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  one-clk-wide timebase enable (nominally 1 Hz); timer advances only when tick=1.
REQ-007 Sensor_sync  input  1  side-street car present, already synchronized.
REQ-008 WR_valor  input  1  pending walk request from the walk-request register.
REQ-009 WR_Reset  output  1  one-clk pulse that clears the walk-request register.
REQ-010 main_light  output  3  main-street lamps {R,Y,G}, exactly one bit high.
REQ-011 side_light  output  3  side-street lamps {R,Y,G}, exactly one bit high.
REQ-012 walk_lamp  output  1  pedestrian walk lamp.
REQ-013 state_out  output  3  current state encoding, for debug/display.

Function
REQ-014 States SHALL be: MG1=0, MG2=1, MY=2, WALK=3, SG1=4, SG2=5, SY=6; code 7 SHALL return to MG1 on the next clk.
REQ-015 Durations: MG1=T_BASE, MG2=T_EXT, MY=T_YEL, WALK=T_EXT, SG1=T_EXT, SG2=T_EXT, SY=T_YEL ticks.
REQ-016 4-bit tick counter cnt SHALL clear to 0 on every state entry; on tick with cnt<dur-1, cnt+1; on tick with cnt==dur-1, state advances on that same edge and cnt=0.
REQ-017 Each state thus lasts exactly dur ticks; no state SHALL change without tick=1.
REQ-018 MG1 expiry: Sensor_sync=1 -> MY; else -> MG2.
REQ-019 MG2 expiry -> MY unconditionally.
REQ-020 MY expiry: WR_valor=1 -> WALK; else -> SG1.
REQ-021 WALK expiry -> SG1.
REQ-022 SG1 expiry: Sensor_sync=1 -> SG2; else -> SY. SG2 expiry -> SY (SG2 entered at most once per cycle).
REQ-023 SY expiry -> MG1.
REQ-024 Branch inputs SHALL be sampled only on the expiry edge; values at other times are ignored.
REQ-025 Lamp decode (Moore, from state register): MG1/MG2 main=G side=R; MY main=Y side=R; WALK main=R side=R walk_lamp=1; SG1/SG2 main=R side=G; SY main=R side=Y.
REQ-026 walk_lamp SHALL be 1 only in WALK.
REQ-027 WR_Reset SHALL be registered and high exactly during the first clk in WALK, else 0; requests arriving later in WALK stay latched for the next round.
REQ-028 WR_valor rising during MG1..MY before the MY expiry edge SHALL be served in the same round.

Reset
REQ-029 Reset_sincronico=1 at a clk edge SHALL force state=MG1, cnt=0, WR_Reset=0 on that edge, overriding tick and all other inputs.
REQ-030 After reset: main_light=3'b001, side_light=3'b100, walk_lamp=0, state_out=0.
REQ-031 Reset asserted mid-state (including WALK) SHALL abort the state with no WR_Reset pulse; timing restarts with a full MG1.

Verification
REQ-032 Defaults, tick every 4 clk, Sensor_sync=0, WR_valor=0 -> MG1 6 ticks, MG2 3, MY 2, SG1 3, SY 2, back to MG1 (16 ticks/round); walk_lamp never 1.
REQ-033 Sensor_sync=1 throughout -> MG1 6, MY 2, SG1 3, SG2 3, SY 2 (MG2 skipped, SG2 taken once).
REQ-034 WR_valor=1 raised during MG2 -> WALK after MY for 3 ticks, all red, walk_lamp=1; WR_Reset high exactly 1 clk at WALK entry; model register clears; next round skips WALK.
REQ-035 WR_valor raised during WALK after the WR_Reset pulse -> remains 1; WALK served again next round.
REQ-036 Reset_sincronico coincident with tick on the MY expiry edge, WR_valor=1 -> state MG1, cnt 0, no WR_Reset pulse; lamps main G/side R on next clk.
REQ-037 tick held 0 for 100 clk in any state -> no state, cnt or output change.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm
//   Two-road intersection controller with an optional pedestrian walk phase.
//   Phase timing is counted in ticks of an external timebase enable; the
//   side-street sensor and the latched walk request steer the phase order.
//
// Parameters
//   T_BASE  base main-green duration in ticks (1..15)
//   T_EXT   main-green extension, walk and side-green duration in ticks (1..15)
//   T_YEL   yellow duration in ticks (1..15)
//
// Ports
//   clk               system clock, rising edge
//   Reset_sincronico  synchronous active-high reset
//   tick              one-clk timebase enable; the phase timer only moves on it
//   Sensor_sync       side-street car present (already synchronized)
//   WR_valor          pending walk request from the external request register
//   WR_Reset          one-clk pulse clearing the request register on walk entry
//   main_light        main-street lamps {R,Y,G}
//   side_light        side-street lamps {R,Y,G}
//   walk_lamp         pedestrian walk lamp
//   state_out         current state code for debug/display
module traffic_light_fsm #(
    parameter int unsigned T_BASE = 6,
    parameter int unsigned T_EXT  = 3,
    parameter int unsigned T_YEL  = 2
) (
    input  logic       clk,
    input  logic       Reset_sincronico,
    input  logic       tick,
    input  logic       Sensor_sync,
    input  logic       WR_valor,
    output logic       WR_Reset,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        MG1  = 3'd0,
        MG2  = 3'd1,
        MY   = 3'd2,
        WALK = 3'd3,
        SG1  = 3'd4,
        SG2  = 3'd5,
        SY   = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t     state;
    state_t     nxt;
    logic [3:0] cnt;
    logic [3:0] last;   // terminal count of the current phase (duration - 1)

    // Lamp pattern {main, side, walk} shown while in state s.
    function automatic logic [6:0] lamps_for(input state_t s);
        case (s)
            MG1, MG2: lamps_for = {LAMP_G, LAMP_R, 1'b0};
            MY:       lamps_for = {LAMP_Y, LAMP_R, 1'b0};
            WALK:     lamps_for = {LAMP_R, LAMP_R, 1'b1};
            SG1, SG2: lamps_for = {LAMP_R, LAMP_G, 1'b0};
            SY:       lamps_for = {LAMP_R, LAMP_Y, 1'b0};
            default:  lamps_for = {LAMP_G, LAMP_R, 1'b0};
        endcase
    endfunction

    always_comb begin
        case (state)
            MG1:     last = 4'(T_BASE - 1);
            MY, SY:  last = 4'(T_YEL - 1);
            default: last = 4'(T_EXT - 1);
        endcase
    end

    // Successor on phase expiry; branch inputs only matter on that edge.
    always_comb begin
        case (state)
            MG1:     nxt = Sensor_sync ? MY : MG2;
            MG2:     nxt = MY;
            MY:      nxt = WR_valor ? WALK : SG1;
            WALK:    nxt = SG1;
            SG1:     nxt = Sensor_sync ? SG2 : SY;
            SG2:     nxt = SY;
            SY:      nxt = MG1;
            default: nxt = MG1;
        endcase
    end

    // Lamps are loaded together with the state so they stay a pure
    // function of the state register while being flop outputs.
    always_ff @(posedge clk) begin
        if (Reset_sincronico) begin
            state    <= MG1;
            cnt      <= '0;
            WR_Reset <= 1'b0;
            {main_light, side_light, walk_lamp} <= lamps_for(MG1);
        end else begin
            WR_Reset <= 1'b0;
            case (state)
                MG1, MG2, MY, WALK, SG1, SG2, SY: begin
                    if (tick) begin
                        if (cnt == last) begin
                            state <= nxt;
                            cnt   <= '0;
                            {main_light, side_light, walk_lamp} <= lamps_for(nxt);
                            // Pulse only on WALK entry so later requests stay latched.
                            if (nxt == WALK)
                                WR_Reset <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    // Unused code 7: recover without waiting for a tick.
                    state <= MG1;
                    cnt   <= '0;
                    {main_light, side_light, walk_lamp} <= lamps_for(MG1);
                end
            endcase
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with default parameters.
// Inputs change on falling edges, outputs are sampled on falling edges.
module tb_traffic_light_fsm;

    localparam int S_MG1  = 0;
    localparam int S_MG2  = 1;
    localparam int S_MY   = 2;
    localparam int S_WALK = 3;
    localparam int S_SG1  = 4;
    localparam int S_SG2  = 5;
    localparam int S_SY   = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       sensor = 1'b0;
    logic       wr_set = 1'b0;
    logic       wr_reg = 1'b0;
    logic       wr_reset;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Model of the external walk-request register.
    always @(posedge clk) begin
        if (wr_set)
            wr_reg <= 1'b1;
        else if (wr_reset)
            wr_reg <= 1'b0;
    end

    traffic_light_fsm #(.T_BASE(6), .T_EXT(3), .T_YEL(2)) dut (
        .clk              (clk),
        .Reset_sincronico (rst),
        .tick             (tick),
        .Sensor_sync      (sensor),
        .WR_valor         (wr_reg),
        .WR_Reset         (wr_reset),
        .main_light       (main_light),
        .side_light       (side_light),
        .walk_lamp        (walk_lamp),
        .state_out        (state_out)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected lamps for a state, straight from the lamp table.
    task automatic check_state(input string tag, input int st);
        logic [2:0] em;
        logic [2:0] es;
        case (st)
            S_MG1, S_MG2: begin em = 3'b001; es = 3'b100; end
            S_MY:         begin em = 3'b010; es = 3'b100; end
            S_WALK:       begin em = 3'b100; es = 3'b100; end
            S_SG1, S_SG2: begin em = 3'b100; es = 3'b001; end
            default:      begin em = 3'b100; es = 3'b010; end
        endcase
        check({tag, ".state"}, 8'(state_out), 8'(st));
        check({tag, ".main"},  8'(main_light), 8'(em));
        check({tag, ".side"},  8'(side_light), 8'(es));
        check({tag, ".walk"},  8'(walk_lamp), (st == S_WALK) ? 8'd1 : 8'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One tick pulse; returns on the falling edge right after the tick edge.
    task automatic tick1();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // n ticks spaced 4 clocks apart: state `during` after the first n-1,
    // state `after` after the n-th.
    task automatic run(input string tag, input int n, input int during, input int after);
        for (int i = 1; i <= n; i++) begin
            tick1();
            check_state(tag, (i == n) ? after : during);
            if (i == n && after != S_WALK)
                check({tag, ".wrr"}, 8'(wr_reset), 8'd0);
            idle(2);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_request();
        @(negedge clk);
        wr_set = 1'b1;
        @(negedge clk);
        wr_set = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(2);
        do_reset();
        check_state("rst", S_MG1);
        check("rst.wrr", 8'(wr_reset), 8'd0);

        // Plain round, no sensor, no walk
        run("r1.mg1", 6, S_MG1, S_MG2);
        run("r1.mg2", 3, S_MG2, S_MY);
        run("r1.my",  2, S_MY,  S_SG1);
        run("r1.sg1", 3, S_SG1, S_SY);
        run("r1.sy",  2, S_SY,  S_MG1);

        // Sensor held high: MG2 skipped, SG2 taken once
        sensor = 1'b1;
        run("r2.mg1", 6, S_MG1, S_MY);
        run("r2.my",  2, S_MY,  S_SG1);
        run("r2.sg1", 3, S_SG1, S_SG2);
        run("r2.sg2", 3, S_SG2, S_SY);
        run("r2.sy",  2, S_SY,  S_MG1);
        sensor = 1'b0;

        // Walk requested during MG2
        run("r3.mg1", 6, S_MG1, S_MG2);
        pulse_request();
        check("r3.req", 8'(wr_reg), 8'd1);
        run("r3.mg2", 3, S_MG2, S_MY);
        run("r3.my",  1, S_MY,  S_MY);
        tick1();
        check_state("r3.walk_in", S_WALK);
        check("r3.wrr_hi", 8'(wr_reset), 8'd1);
        @(negedge clk);
        check("r3.wrr_lo", 8'(wr_reset), 8'd0);
        check("r3.req_clr", 8'(wr_reg), 8'd0);
        // New request arriving inside WALK stays latched
        pulse_request();
        run("r3.walk", 3, S_WALK, S_SG1);
        check("r3.req_kept", 8'(wr_reg), 8'd1);
        run("r3.sg1", 3, S_SG1, S_SY);
        run("r3.sy",  2, S_SY,  S_MG1);

        // Latched request served next round
        run("r4.mg1", 6, S_MG1, S_MG2);
        run("r4.mg2", 3, S_MG2, S_MY);
        run("r4.my",  1, S_MY,  S_MY);
        tick1();
        check_state("r4.walk_in", S_WALK);
        check("r4.wrr_hi", 8'(wr_reset), 8'd1);
        idle(3);
        run("r4.walk", 3, S_WALK, S_SG1);
        check("r4.req_clr", 8'(wr_reg), 8'd0);
        run("r4.sg1", 3, S_SG1, S_SY);
        run("r4.sy",  2, S_SY,  S_MG1);

        // Next round skips WALK
        run("r5.mg1", 6, S_MG1, S_MG2);
        run("r5.mg2", 3, S_MG2, S_MY);
        run("r5.my",  2, S_MY,  S_SG1);
        run("r5.sg1", 3, S_SG1, S_SY);
        run("r5.sy",  2, S_SY,  S_MG1);

        // Reset coincident with tick on the MY expiry edge, request pending
        pulse_request();
        run("r6.mg1", 6, S_MG1, S_MG2);
        run("r6.mg2", 3, S_MG2, S_MY);
        run("r6.my",  1, S_MY,  S_MY);
        @(negedge clk);
        tick = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;
        check_state("r6.rst", S_MG1);
        check("r6.wrr", 8'(wr_reset), 8'd0);
        check("r6.req", 8'(wr_reg), 8'd1);
        idle(2);
        // Counter restarted: a full MG1 follows
        run("r6.mg1b", 6, S_MG1, S_MG2);
        run("r6.mg2b", 3, S_MG2, S_MY);
        run("r6.myb",  1, S_MY,  S_MY);
        tick1();
        check_state("r6.walk_in", S_WALK);
        idle(3);
        // Reset in the middle of WALK
        run("r6.walk", 1, S_WALK, S_WALK);
        do_reset();
        check_state("r6.rst_walk", S_MG1);
        check("r6.wrr2", 8'(wr_reset), 8'd0);

        // Tick held low for 100 clocks mid-phase
        run("r7.mg1a", 3, S_MG1, S_MG1);
        idle(100);
        check_state("r7.hold", S_MG1);
        check("r7.wrr", 8'(wr_reset), 8'd0);
        run("r7.mg1b", 3, S_MG1, S_MG2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
